load_store_unit: RTL and testbench

MEM-stage load/store unit of the five-stage MIPS core. It consumes the effective address (base register + sign-extended immediate, summed in EX) and the store data for LB, LBU, LW, SB and SW. It runs a request/acknowledge transaction on the data bus and stalls the pipeline until the transaction completes. It returns aligned, extended load data to the writeback path.

---
 rtl/load_store_unit.sv | 166 ++++++++++++++++
 tb/tb_load_store_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: runs one req/ack data-bus transaction per load or store,
// stalls the pipeline while it is outstanding and returns aligned, extended load data.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read_flag,
  input  logic                  mem_write_flag,
  input  logic                  mem_word_flag,
  input  logic                  mem_sign_ext_flag,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic                  flush,
  input  logic                  stall_in,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [3:0]            bus_sel,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  input  logic                  bus_ack,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  stall_req,
  output logic                  addr_error
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            state_q,     state_d;
  logic                  bus_req_q,   bus_req_d;
  logic                  bus_we_q,    bus_we_d;
  logic [3:0]            bus_sel_q,   bus_sel_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q,  bus_addr_d;
  logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
  logic [DATA_WIDTH-1:0] load_data_q, load_data_d;
  logic                  word_q,      word_d;
  logic                  sext_q,      sext_d;
  logic [1:0]            lane_q,      lane_d;
  logic                  kill_q,      kill_d;

  logic                  access;
  logic                  misaligned;
  logic                  issue;
  logic [7:0]            rd_byte;
  logic [DATA_WIDTH-1:0] load_result;

  assign access     = (mem_read_flag | mem_write_flag) & ~flush;
  assign misaligned = mem_word_flag & (mem_addr[1:0] != 2'b00);
  assign issue      = access & ~misaligned;

  // Lane and extension come from values captured at issue, so the result does not
  // depend on the MEM-stage inputs staying put until the acknowledge.
  always_comb begin
    case (lane_q)
      2'd0:    rd_byte = bus_rdata[7:0];
      2'd1:    rd_byte = bus_rdata[15:8];
      2'd2:    rd_byte = bus_rdata[23:16];
      default: rd_byte = bus_rdata[31:24];
    endcase
  end

  assign load_result = bus_we_q ? '0
                     : word_q   ? bus_rdata
                     : {{24{sext_q & rd_byte[7]}}, rd_byte};

  always_comb begin
    // NOTE: every _d starts as its _q so no path through the case leaves a signal
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_sel_d   = bus_sel_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    load_data_d = load_data_q;
    word_d      = word_q;
    sext_d      = sext_q;
    lane_d      = lane_q;
    kill_d      = kill_q;

    case (state_q)
      S_IDLE: begin
        if (issue) begin
          state_d     = S_BUSY;
          bus_req_d   = 1'b1;
          bus_we_d    = mem_write_flag;
          bus_sel_d   = mem_word_flag ? 4'hF : (4'b0001 << mem_addr[1:0]);
          bus_addr_d  = {mem_addr[ADDR_WIDTH-1:2], 2'b00};
          bus_wdata_d = !mem_write_flag ? '0
                      : mem_word_flag   ? mem_write_data
                      : {4{mem_write_data[7:0]}};
          word_d      = mem_word_flag;
          sext_d      = mem_sign_ext_flag;
          lane_d      = mem_addr[1:0];
          kill_d      = 1'b0;
        end
      end
      S_BUSY: begin
        // A flush seen at any point in BUSY squashes the result; the request stays up.
        if (flush) kill_d = 1'b1;
        if (bus_ack) begin
          bus_req_d = 1'b0;
          if (flush || kill_q) begin
            state_d     = S_IDLE;
            load_data_d = '0;
          end else begin
            state_d     = S_DONE;
            load_data_d = load_result;
          end
        end
      end
      S_DONE: begin
        if (flush) begin
          state_d     = S_IDLE;
          load_data_d = '0;
        end else if (!stall_in) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge _d values.
    if (rst) begin
      state_q     <= S_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_sel_q   <= 4'h0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      load_data_q <= '0;
      word_q      <= 1'b0;
      sext_q      <= 1'b0;
      lane_q      <= 2'd0;
      kill_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_sel_q   <= bus_sel_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      load_data_q <= load_data_d;
      word_q      <= word_d;
      sext_q      <= sext_d;
      lane_q      <= lane_d;
      kill_q      <= kill_d;
    end
  end

  assign bus_req    = bus_req_q;
  assign bus_we     = bus_we_q;
  assign bus_sel    = bus_sel_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign load_data  = load_data_q;
  assign stall_req  = ~rst & (((state_q == S_IDLE) & issue) | (state_q == S_BUSY));
  assign addr_error = ~rst & access & misaligned;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases followed by randomized
// transactions compared against an arithmetic reference model.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        mem_read_flag, mem_write_flag, mem_word_flag, mem_sign_ext_flag;
  logic [31:0] mem_addr, mem_write_data;
  logic        flush, stall_in;
  logic        bus_req, bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_ack;
  logic [31:0] load_data;
  logic        stall_req, addr_error;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .mem_read_flag(mem_read_flag), .mem_write_flag(mem_write_flag),
    .mem_word_flag(mem_word_flag), .mem_sign_ext_flag(mem_sign_ext_flag),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .flush(flush), .stall_in(stall_in),
    .bus_req(bus_req), .bus_we(bus_we), .bus_sel(bus_sel), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .load_data(load_data), .stall_req(stall_req), .addr_error(addr_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_read_flag     = 1'b0;
    mem_write_flag    = 1'b0;
    mem_word_flag     = 1'b0;
    mem_sign_ext_flag = 1'b0;
    mem_addr          = $urandom;
    mem_write_data    = $urandom;
    flush             = 1'b0;
    stall_in          = 1'b0;
    bus_ack           = 1'($urandom % 2);
    bus_rdata         = $urandom;
  endtask

  // Reference model: little-endian lanes, byte stores replicated, byte loads extended.
  function automatic logic [3:0] model_sel(input bit word, input logic [31:0] a);
    return word ? 4'hF : 4'(1 << a[1:0]);
  endfunction

  function automatic logic [31:0] model_wdata(input bit word, input logic [31:0] wd);
    return word ? wd : (wd & 32'hFF) * 32'h0101_0101;
  endfunction

  function automatic logic [31:0] model_load(input bit word, input bit sext,
                                             input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] b;
    if (word) return rd;
    b = (rd >> (8 * a[1:0])) & 32'hFF;
    if (sext && b >= 32'd128) return b + 32'hFFFF_FF00;
    return b;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, ".bus_req"},    32'(bus_req),    32'd0);
    check({tag, ".bus_we"},     32'(bus_we),     32'd0);
    check({tag, ".bus_sel"},    32'(bus_sel),    32'd0);
    check({tag, ".bus_addr"},   bus_addr,        32'd0);
    check({tag, ".bus_wdata"},  bus_wdata,       32'd0);
    check({tag, ".load_data"},  load_data,       32'd0);
    check({tag, ".stall_req"},  32'(stall_req),  32'd0);
    check({tag, ".addr_error"}, 32'(addr_error), 32'd0);
  endtask

  // One complete memory instruction, entered and left at posedge+1 with the unit in IDLE.
  task automatic run_access(input bit is_load, input bit word, input bit sext,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rd, input int delay,
                            input bit flush_busy, input int hold, input bit flush_done);
    logic [31:0] exp_ld;
    bit mis;
    mis = word && (a[1:0] != 2'b00);
    exp_ld = is_load ? model_load(word, sext, a, rd) : 32'd0;

    mem_read_flag     = is_load;
    mem_write_flag    = !is_load;
    mem_word_flag     = word;
    mem_sign_ext_flag = sext;
    mem_addr          = a;
    mem_write_data    = wd;
    flush             = 1'b0;
    stall_in          = 1'b0;
    bus_ack           = 1'($urandom % 2);
    bus_rdata         = $urandom;
    #1;
    check("c0.addr_error", 32'(addr_error), 32'(mis));

    if (mis) begin
      check("mis.stall_req", 32'(stall_req), 32'd0);
      tick();
      check("mis.bus_req", 32'(bus_req), 32'd0);
      check("mis.stall_req_next", 32'(stall_req), 32'd0);
      idle_inputs();
      tick();
      check("mis.bus_req_after", 32'(bus_req), 32'd0);
      return;
    end

    check("c0.stall_req", 32'(stall_req), 32'd1);
    check("c0.bus_req", 32'(bus_req), 32'd0);
    tick();

    for (int i = 0; i <= delay; i++) begin
      bus_ack   = (i == delay);
      bus_rdata = (i == delay) ? rd : $urandom;
      flush     = flush_busy;
      #1;
      check("busy.bus_req",   32'(bus_req),   32'd1);
      check("busy.bus_we",    32'(bus_we),    32'(!is_load));
      check("busy.bus_sel",   32'(bus_sel),   32'(model_sel(word, a)));
      check("busy.bus_addr",  bus_addr,       a & ~32'h3);
      check("busy.stall_req", 32'(stall_req), 32'd1);
      if (!is_load) check("busy.bus_wdata", bus_wdata, model_wdata(word, wd));
      tick();
    end

    bus_ack   = 1'($urandom % 2);
    bus_rdata = $urandom;

    if (flush_busy) begin
      check("flush.stall_req", 32'(stall_req), 32'd0);
      check("flush.bus_req",   32'(bus_req),   32'd0);
      check("flush.load_data", load_data,      32'd0);
      idle_inputs();
      tick();
      check("flush.idle_stall", 32'(stall_req), 32'd0);
      check("flush.idle_req",   32'(bus_req),   32'd0);
      return;
    end

    flush = 1'b0;
    #1;
    check("done.stall_req", 32'(stall_req), 32'd0);
    check("done.bus_req",   32'(bus_req),   32'd0);
    check("done.load_data", load_data,      exp_ld);

    for (int h = 0; h < hold; h++) begin
      stall_in = 1'b1;
      bus_ack  = 1'($urandom % 2);
      tick();
      check("hold.load_data", load_data,      exp_ld);
      check("hold.bus_req",   32'(bus_req),   32'd0);
      check("hold.stall_req", 32'(stall_req), 32'd0);
    end

    if (flush_done) begin
      flush = 1'b1;
      tick();
      check("dflush.load_data", load_data, 32'd0);
      idle_inputs();
      #1;
      check("dflush.stall_req", 32'(stall_req), 32'd0);
      check("dflush.bus_req",   32'(bus_req),   32'd0);
      return;
    end

    stall_in = 1'b0;
    tick();
    idle_inputs();
    #1;
    check("next.stall_req", 32'(stall_req), 32'd0);
    check("next.bus_req",   32'(bus_req),   32'd0);
    check("next.load_data", load_data,      exp_ld);
  endtask

  initial begin
    bit          r_load, r_word, r_sext;
    logic [31:0] r_addr;

    idle_inputs();
    rst     = 1'b1;
    bus_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check("idle.stall_req", 32'(stall_req), 32'd0);
    check("idle.bus_req",   32'(bus_req),   32'd0);
    tick();

    // LW, zero-wait ack
    run_access(1'b1, 1'b1, 1'b0, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 0, 1'b0, 0, 1'b0);
    // LB / LBU on lane 3
    run_access(1'b1, 1'b0, 1'b1, 32'h0000_2003, 32'h0, 32'h8012_3456, 0, 1'b0, 0, 1'b0);
    run_access(1'b1, 1'b0, 1'b0, 32'h0000_2003, 32'h0, 32'h8012_3456, 1, 1'b0, 0, 1'b0);
    // SB with 3 BUSY cycles
    run_access(1'b0, 1'b0, 1'b0, 32'h0000_3001, 32'h0000_00AB, 32'h0, 2, 1'b0, 0, 1'b0);
    // misaligned LW
    run_access(1'b1, 1'b1, 1'b0, 32'h0000_4002, 32'h0, 32'h0, 0, 1'b0, 0, 1'b0);
    // flush during BUSY
    run_access(1'b1, 1'b1, 1'b0, 32'h0000_6000, 32'h0, 32'h1234_5678, 2, 1'b1, 0, 1'b0);
    // stall_in held in DONE for 2 cycles
    run_access(1'b1, 1'b0, 1'b1, 32'h0000_7001, 32'h0, 32'h0000_F500, 1, 1'b0, 2, 1'b0);
    // flush in DONE
    run_access(1'b1, 1'b1, 1'b0, 32'h0000_7100, 32'h0, 32'hCAFE_F00D, 0, 1'b0, 1, 1'b1);
    // SW, word placement
    run_access(1'b0, 1'b1, 1'b0, 32'h0000_7200, 32'h0BAD_CAFE, 32'h0, 1, 1'b0, 0, 1'b0);

    // reset in BUSY
    mem_write_flag = 1'b1;
    mem_word_flag  = 1'b1;
    mem_addr       = 32'h0000_5008;
    mem_write_data = 32'h5555_AAAA;
    bus_ack        = 1'b0;
    tick();
    check("rstbusy.bus_req", 32'(bus_req), 32'd1);
    rst = 1'b1;
    tick();
    check_all_zero("rstbusy");
    rst = 1'b0;
    idle_inputs();
    tick();
    check("rstbusy.idle_req",   32'(bus_req),   32'd0);
    check("rstbusy.idle_stall", 32'(stall_req), 32'd0);

    for (int n = 0; n < 60; n++) begin
      r_load = 1'($urandom % 2);
      r_word = 1'($urandom % 2);
      r_sext = 1'($urandom % 2);
      r_addr = $urandom;
      if (r_word && ($urandom % 4 != 0)) r_addr[1:0] = 2'b00;
      run_access(r_load, r_word, r_sext, r_addr, $urandom, $urandom,
                 int'($urandom_range(0, 4)), ($urandom % 8) == 0,
                 int'($urandom_range(0, 2)), ($urandom % 10) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
